// File: rtl/pkg_tpu.sv
// Shared TPU definitions: default table geometry and the types that travel
// between the issue stage, the vector lanes and the commit table.
package pkg_tpu;

   localparam int NUM_LANE         = 4;
   localparam int NUM_ENTRY_HAZARD = 8;
   localparam int WIDTH_ISSUE_NO   = $clog2(NUM_ENTRY_HAZARD);

   typedef logic [WIDTH_ISSUE_NO-1:0] issue_no_t;

   // One commit-table entry: valid, lanes that must commit, lanes that have.
   typedef struct packed {
      logic                v;
      logic [NUM_LANE-1:0] en_lane;
      logic [NUM_LANE-1:0] en_commit;
   } commit_tab_v;

   // Per-lane committed issue numbers, lane 0 in the lowest slice.
   typedef issue_no_t [NUM_LANE-1:0] commit_no_vec_t;

endpackage

// File: rtl/commit_table_v_commit_ptr.sv
// Circular pointer with a wrap bit; the wrap bit separates full from empty
// when the head and tail indices coincide.
module commit_ptr #(
   parameter int WIDTH_NO = 3
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                clear,
   input  logic                advance,
   output logic [WIDTH_NO-1:0] idx,
   output logic                wrap
);

   // Advance modulo 2**WIDTH_NO; the carry out of the index toggles wrap.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         {wrap, idx} <= '0;
      end else if (clear) begin
         {wrap, idx} <= '0;
      end else if (advance) begin
         {wrap, idx} <= {wrap, idx} + (WIDTH_NO + 1)'(1);
      end
   end

endmodule

// File: rtl/commit_table_v.sv
// In-order commit table: allocates an entry per issued vector instruction,
// collects per-lane commit strobes and retires the oldest complete entry.
module commit_table_v #(
   parameter int NUM_ENTRY = pkg_tpu::NUM_ENTRY_HAZARD,
   parameter int NUM_LANE  = pkg_tpu::NUM_LANE,
   parameter int WIDTH_NO  = $clog2(NUM_ENTRY)
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         I_Flush,
   input  logic                         I_Issue,
   input  logic [NUM_LANE-1:0]          I_En_Lane,
   output logic                         O_Issue_Ack,
   output logic [WIDTH_NO-1:0]          O_Issue_No,
   input  logic [NUM_LANE-1:0]          I_Commit,
   input  logic [NUM_LANE*WIDTH_NO-1:0] I_Commit_No,
   output logic                         O_Commit,
   output logic [WIDTH_NO-1:0]          O_Commit_No,
   output logic                         O_Full,
   output logic                         O_Empty,
   output logic [$clog2(NUM_ENTRY+1)-1:0] O_Count,
   output logic                         O_Err
);

   localparam int CNT_W = $clog2(NUM_ENTRY + 1);

   logic [NUM_ENTRY-1:0] v;
   logic [NUM_LANE-1:0]  en_lane   [NUM_ENTRY];
   logic [NUM_LANE-1:0]  en_commit [NUM_ENTRY];

   logic [WIDTH_NO-1:0]  head_idx, tail_idx;
   logic                 head_wrap, tail_wrap;
   logic [WIDTH_NO-1:0]  commit_no [NUM_LANE];
   logic [NUM_LANE-1:0]  commit_ok, commit_bad;
   logic                 retire;

   commit_ptr #(.WIDTH_NO(WIDTH_NO)) u_head (
      .clock   (clock),
      .reset   (reset),
      .clear   (I_Flush),
      .advance (retire),
      .idx     (head_idx),
      .wrap    (head_wrap)
   );

   commit_ptr #(.WIDTH_NO(WIDTH_NO)) u_tail (
      .clock   (clock),
      .reset   (reset),
      .clear   (I_Flush),
      .advance (O_Issue_Ack),
      .idx     (tail_idx),
      .wrap    (tail_wrap)
   );

   assign O_Full      = (head_idx == tail_idx) && (head_wrap != tail_wrap);
   assign O_Empty     = (head_idx == tail_idx) && (head_wrap == tail_wrap);
   assign O_Issue_Ack = I_Issue & ~O_Full;
   assign O_Issue_No  = tail_idx;

   // Head retires once every enabled lane has committed (en_lane=0 retires at once).
   assign retire = v[head_idx] && (en_commit[head_idx] == en_lane[head_idx]);

   // Classify each lane strobe against cycle-start entry state.
   always_comb begin
      commit_ok  = '0;
      commit_bad = '0;
      for (int l = 0; l < NUM_LANE; l++) begin
         commit_no[l] = I_Commit_No[l*WIDTH_NO +: WIDTH_NO];
         if (I_Commit[l]) begin
            if (v[commit_no[l]] && en_lane[commit_no[l]][l]) begin
               commit_ok[l] = 1'b1;
            end else begin
               commit_bad[l] = 1'b1;
            end
         end
      end
   end

   // Entry storage: flush clears everything, otherwise commit, retire, allocate.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         v <= '0;
         for (int e = 0; e < NUM_ENTRY; e++) begin
            en_lane[e]   <= '0;
            en_commit[e] <= '0;
         end
      end else if (I_Flush) begin
         v <= '0;
         for (int e = 0; e < NUM_ENTRY; e++) begin
            en_commit[e] <= '0;
         end
      end else begin
         for (int l = 0; l < NUM_LANE; l++) begin
            if (commit_ok[l]) begin
               en_commit[commit_no[l]][l] <= 1'b1;
            end
         end
         if (retire) begin
            v[head_idx] <= 1'b0;
         end
         if (O_Issue_Ack) begin
            v[tail_idx]         <= 1'b1;
            en_lane[tail_idx]   <= I_En_Lane;
            en_commit[tail_idx] <= '0;
         end
      end
   end

   // Registered one-cycle retire pulse carrying the retired issue number.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         O_Commit    <= 1'b0;
         O_Commit_No <= '0;
      end else if (I_Flush) begin
         O_Commit    <= 1'b0;
      end else begin
         O_Commit <= retire;
         if (retire) begin
            O_Commit_No <= head_idx;
         end
      end
   end

   // Occupancy: +1 per accepted issue, -1 per retire.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         O_Count <= '0;
      end else if (I_Flush) begin
         O_Count <= '0;
      end else begin
         O_Count <= O_Count + CNT_W'(O_Issue_Ack) - CNT_W'(retire);
      end
   end

   // Sticky flag for any commit aimed at an invalid entry or disabled lane.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         O_Err <= 1'b0;
      end else if (!I_Flush && (|commit_bad)) begin
         O_Err <= 1'b1;
      end
   end

endmodule

// File: doc/commit_table_v.md
COMMIT_TABLE_V -- requirements
Module: commit_table_v

Interface
REQ-001 SHALL have parameter NUM_ENTRY, default 8, giving the number of commit-table entries (power of two, at least 2).
REQ-002 SHALL have parameter NUM_LANE, default 4, giving the number of vector lanes tracked per entry.
REQ-003 SHALL have parameter WIDTH_NO, default $clog2(NUM_ENTRY), giving the issue-number width.
REQ-004 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port I_Flush, input, 1 bit: synchronous clear of all entries.
REQ-007 SHALL have port I_Issue, input, 1 bit: request to allocate one entry.
REQ-008 SHALL have port I_En_Lane, input, NUM_LANE bits: lanes that must commit the issued instruction.
REQ-009 SHALL have port O_Issue_Ack, output, 1 bit: allocation accepted this cycle.
REQ-010 SHALL have port O_Issue_No, output, WIDTH_NO bits: tail index allocated on acceptance.
REQ-011 SHALL have port I_Commit, input, NUM_LANE bits: per-lane commit strobes.
REQ-012 SHALL have port I_Commit_No, input, NUM_LANE x WIDTH_NO bits: per-lane committed issue number.
REQ-013 SHALL have port O_Commit, output, 1 bit: one-cycle retire pulse.
REQ-014 SHALL have port O_Commit_No, output, WIDTH_NO bits: issue number retired.
REQ-015 SHALL have port O_Full, output, 1 bit: table full.
REQ-016 SHALL have port O_Empty, output, 1 bit: table empty.
REQ-017 SHALL have port O_Count, output, $clog2(NUM_ENTRY+1) bits: number of occupied entries.
REQ-018 SHALL have port O_Err, output, 1 bit: sticky illegal-commit flag.

Function
REQ-019 SHALL hold, per entry: v, en_lane[NUM_LANE], en_commit[NUM_LANE]; plus head and tail pointers, each with a wrap bit.
REQ-020 SHALL compute O_Issue_Ack = I_Issue & ~O_Full combinationally, and drive O_Issue_No = tail index at all times.
REQ-021 SHALL, on an accepted issue, write the tail entry with v=1, en_lane=I_Em_Lane, en_commit=0, and advance tail modulo NUM_ENTRY, toggling its wrap bit on wrap.
REQ-022 SHALL, when I_Commit[l]=1, set en_commit[l] of entry I_Commit_No[l] only if that entry's v=1 and en_lane[l]=1; all lanes are processed in the same cycle.
REQ-023 SHALL ignore any other commit (entry invalid, or lane not enabled) and set O_Err, which holds until reset.
REQ-024 SHALL treat an entry as complete when v=1 and en_commit==en_lane; an issue with en_lane=0 is complete immediately.
REQ-025 SHALL retire strictly in order: if the head entry is complete at the start of a cycle, that edge clears v, advances head, and registers O_Commit=1 with O_Commit_No=old head for exactly one cycle.
REQ-026 SHALL retire at most one entry per cycle; latency from the last lane-commit edge to O_Commit high is one cycle.
REQ-027 SHALL evaluate full and empty from cycle-start state: O_Full = (head index==tail index) & (wrap bits differ); O_Empty = pointers equal.
REQ-028 SHALL never bypass: when full, an issue is refused even if a retire happens in the same cycle; a commit aimed at an entry issued in the same cycle is illegal (REQ-023).
REQ-029 SHALL update O_Count by +1 per accepted issue, -1 per retire, and leave it unchanged on a simultaneous issue and retire.
REQ-030 SHALL make I_Flush dominate: all v cleared, head=tail=0, O_Count=0, O_Commit=0 the next cycle, issue and commit ignored that cycle; O_Err is kept.

Reset
REQ-031 SHALL, while reset=0, force asynchronously: all entries v=0, en_lane=0, en_commit=0; head=tail=0 with wrap bits 0; O_Commit=0; O_Commit_No=0; O_Count=0; O_Err=0.
REQ-032 SHALL show O_Empty=1, O_Full=0, O_Issue_No=0 after reset; a reset in mid-operation discards all pending entries without a retire pulse.

Structure
REQ-033 SHALL take issue_no_t, commit_tab_v, NUM_LANE and NUM_ENTRY_HAZARD from pkg_tpu; the per-lane commit-number vector typedef SHALL be added to pkg_tpu.
REQ-034 SHALL have one natural sub-module, commit_ptr: a pointer with wrap bit and advance enable, instantiated for both head and tail.

Verification
REQ-035 SHALL cover: reset, then issue en_lane=4'b1111 -> O_Issue_No=0 and Ack=1; lanes 0-3 commit number 0 over 4 cycles -> O_Commit=1, O_Commit_No=0 one cycle after the last commit.
REQ-036 SHALL cover: 8 issues with no commits -> O_Full=1, O_Count=8; a 9th issue -> Ack=0; wrap after 8 retires -> next O_Issue_No=0.
REQ-037 SHALL cover: issue #0 en=0011 and #1 en=0001; commit #1 first -> no retire; then commit #0 on lanes 0 and 1 -> retires 0 then 1 on consecutive cycles.
REQ-038 SHALL cover: commit lane 2 to entry 0 when en_lane=0001 -> O_Err=1 and entry 0 unchanged.
REQ-039 SHALL cover: full table plus issue plus completed head in the same cycle -> retire, Ack=0, O_Count=7.
REQ-040 SHALL cover: I_Flush with 3 entries pending -> O_Empty=1 and O_Count=0 next cycle, with no O_Commit pulse.
